// File: rtl/vxe_vpu_regf_pkg.sv
// Shared constants for the VPU per-thread register file: register index map and widths.
package vxe_vpu_regf_pkg;

    localparam int unsigned VPU_ACC_W  = 32;
    localparam int unsigned VPU_VL_W   = 20;
    localparam int unsigned VPU_ADDR_W = 38;
    localparam int unsigned VPU_TH_W   = 3;

    localparam logic [2:0] VPU_REG_IDX_ACC = 3'd0;
    localparam logic [2:0] VPU_REG_IDX_VL  = 3'd1;
    localparam logic [2:0] VPU_REG_IDX_EN  = 3'd2;
    localparam logic [2:0] VPU_REG_IDX_RS  = 3'd3;
    localparam logic [2:0] VPU_REG_IDX_RT  = 3'd4;
    localparam logic [2:0] VPU_REG_IDX_RD  = 3'd5;
    localparam logic [2:0] VPU_REG_IDX_IGN = 3'd7;

endpackage

// File: rtl/vxe_vpu_regf_thread.sv
// One thread's VPU register set. Merges ECU write, acc write-back and element advance
// (ECU > write-back > advance on the same register) and keeps a registered active flag.
module vxe_vpu_regf_thread
    import vxe_vpu_regf_pkg::*;
#(
    parameter int unsigned ACC_W  = VPU_ACC_W,
    parameter int unsigned VL_W   = VPU_VL_W,
    parameter int unsigned ADDR_W = VPU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        ridx,
    input  logic [ADDR_W-1:0] data,
    input  logic              adv,
    input  logic              acc_we,
    input  logic [ACC_W-1:0]  acc_data,
    output logic [ACC_W-1:0]  acc_q,
    output logic [VL_W-1:0]   vl_q,
    output logic              en_q,
    output logic [ADDR_W-1:0] rs_q,
    output logic [ADDR_W-1:0] rt_q,
    output logic [ADDR_W-1:0] rd_q,
    output logic [ACC_W-1:0]  acc_d,
    output logic [VL_W-1:0]   vl_d,
    output logic              en_d,
    output logic [ADDR_W-1:0] rs_d,
    output logic [ADDR_W-1:0] rt_d,
    output logic [ADDR_W-1:0] rd_d,
    output logic              active_q
);

    // Next state: apply lowest priority first so later assignments win.
    always_comb begin
        acc_d = acc_q;
        vl_d  = vl_q;
        en_d  = en_q;
        rs_d  = rs_q;
        rt_d  = rt_q;
        rd_d  = rd_q;
        if (adv) begin
            rs_d = rs_q + ADDR_W'(1);
            rt_d = rt_q + ADDR_W'(1);
            rd_d = rd_q + ADDR_W'(1);
            vl_d = (vl_q != '0) ? vl_q - VL_W'(1) : '0;
        end
        if (acc_we) begin
            acc_d = acc_data;
        end
        if (wr_en) begin
            case (ridx)
                VPU_REG_IDX_ACC: acc_d = data[ACC_W-1:0];
                VPU_REG_IDX_VL:  vl_d  = data[VL_W-1:0];
                VPU_REG_IDX_EN:  en_d  = data[0];
                VPU_REG_IDX_RS:  rs_d  = data;
                VPU_REG_IDX_RT:  rt_d  = data;
                VPU_REG_IDX_RD:  rd_d  = data;
                default: ;  // reserved and IGN indices drop the write
            endcase
        end
    end

    // Storage and active flag; active is taken from the post-update state.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            vl_q     <= '0;
            en_q     <= 1'b0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            active_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            vl_q     <= vl_d;
            en_q     <= en_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            active_q <= en_d && (vl_d != '0);
        end
    end

endmodule

// File: rtl/vxe_vpu_regf.sv
// VPU per-thread register file with registered read port.
// Optional macro VXE_VPU_REGF_BYPASS_EN: read port forwards same-cycle updates.
module vxe_vpu_regf
    import vxe_vpu_regf_pkg::*;
#(
    parameter int unsigned NTHREADS = 8,
    parameter int unsigned ACC_W    = VPU_ACC_W,
    parameter int unsigned VL_W     = VPU_VL_W,
    parameter int unsigned ADDR_W   = VPU_ADDR_W,
    parameter int unsigned TH_W     = VPU_TH_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [TH_W-1:0]     i_th,
    input  logic [2:0]          i_ridx,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_data,
    input  logic                i_adv,
    input  logic [TH_W-1:0]     i_adv_th,
    input  logic                i_acc_we,
    input  logic [TH_W-1:0]     i_acc_th,
    input  logic [ACC_W-1:0]    i_acc_data,
    input  logic [TH_W-1:0]     i_rd_th,
    output logic [ACC_W-1:0]    o_acc,
    output logic [VL_W-1:0]     o_vl,
    output logic                o_en,
    output logic [ADDR_W-1:0]   o_rs,
    output logic [ADDR_W-1:0]   o_rt,
    output logic [ADDR_W-1:0]   o_rd,
    output logic [NTHREADS-1:0] o_active
);

`ifdef VXE_VPU_REGF_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic [ACC_W-1:0]  acc_q [NTHREADS];
    logic [VL_W-1:0]   vl_q  [NTHREADS];
    logic              en_q  [NTHREADS];
    logic [ADDR_W-1:0] rs_q  [NTHREADS];
    logic [ADDR_W-1:0] rt_q  [NTHREADS];
    logic [ADDR_W-1:0] rd_q  [NTHREADS];
    logic [ACC_W-1:0]  acc_d [NTHREADS];
    logic [VL_W-1:0]   vl_d  [NTHREADS];
    logic              en_d  [NTHREADS];
    logic [ADDR_W-1:0] rs_d  [NTHREADS];
    logic [ADDR_W-1:0] rt_d  [NTHREADS];
    logic [ADDR_W-1:0] rd_d  [NTHREADS];
    logic [NTHREADS-1:0] active;

    for (genvar g = 0; g < NTHREADS; g++) begin : g_thread
        vxe_vpu_regf_thread #(
            .ACC_W  (ACC_W),
            .VL_W   (VL_W),
            .ADDR_W (ADDR_W)
        ) u_thread (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (i_wr_en && (i_th == TH_W'(g))),
            .ridx     (i_ridx),
            .data     (i_data),
            .adv      (i_adv && (i_adv_th == TH_W'(g))),
            .acc_we   (i_acc_we && (i_acc_th == TH_W'(g))),
            .acc_data (i_acc_data),
            .acc_q    (acc_q[g]),
            .vl_q     (vl_q[g]),
            .en_q     (en_q[g]),
            .rs_q     (rs_q[g]),
            .rt_q     (rt_q[g]),
            .rd_q     (rd_q[g]),
            .acc_d    (acc_d[g]),
            .vl_d     (vl_d[g]),
            .en_d     (en_d[g]),
            .rs_d     (rs_d[g]),
            .rt_d     (rt_d[g]),
            .rd_d     (rd_d[g]),
            .active_q (active[g])
        );
    end

    assign o_active = active;

    // Registered read mux; bypass selects the post-priority next state of the read thread.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_acc <= '0;
            o_vl  <= '0;
            o_en  <= 1'b0;
            o_rs  <= '0;
            o_rt  <= '0;
            o_rd  <= '0;
        end else begin
            o_acc <= Bypass ? acc_d[i_rd_th] : acc_q[i_rd_th];
            o_vl  <= Bypass ? vl_d[i_rd_th]  : vl_q[i_rd_th];
            o_en  <= Bypass ? en_d[i_rd_th]  : en_q[i_rd_th];
            o_rs  <= Bypass ? rs_d[i_rd_th]  : rs_q[i_rd_th];
            o_rt  <= Bypass ? rt_d[i_rd_th]  : rt_q[i_rd_th];
            o_rd  <= Bypass ? rd_d[i_rd_th]  : rd_q[i_rd_th];
        end
    end

endmodule

// File: tb/tb_vxe_vpu_regf.sv
// Directed self-checking bench for vxe_vpu_regf.
module tb_vxe_vpu_regf;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   i_th, i_ridx, i_adv_th, i_acc_th, i_rd_th;
    logic         i_wr_en, i_adv, i_acc_we;
    logic [37:0]  i_data;
    logic [31:0]  i_acc_data;
    logic [31:0]  o_acc;
    logic [19:0]  o_vl;
    logic         o_en;
    logic [37:0]  o_rs, o_rt, o_rd;
    logic [7:0]   o_active;

    int errors = 0;
    int checks = 0;

    vxe_vpu_regf dut (
        .clk        (clk),
        .rst        (rst),
        .i_th       (i_th),
        .i_ridx     (i_ridx),
        .i_wr_en    (i_wr_en),
        .i_data     (i_data),
        .i_adv      (i_adv),
        .i_adv_th   (i_adv_th),
        .i_acc_we   (i_acc_we),
        .i_acc_th   (i_acc_th),
        .i_acc_data (i_acc_data),
        .i_rd_th    (i_rd_th),
        .o_acc      (o_acc),
        .o_vl       (o_vl),
        .o_en       (o_en),
        .o_rs       (o_rs),
        .o_rt       (o_rt),
        .o_rd       (o_rd),
        .o_active   (o_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ecu_wr(input logic [2:0] th, input logic [2:0] idx, input logic [37:0] d);
        i_th    = th;
        i_ridx  = idx;
        i_data  = d;
        i_wr_en = 1'b1;
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] th);
        i_rd_th = th;
        tick();
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] acc, input logic [19:0] vl,
                            input logic en, input logic [37:0] rs, input logic [37:0] rt,
                            input logic [37:0] rdv);
        chk({tag, ".acc"}, 64'(o_acc), 64'(acc));
        chk({tag, ".vl"},  64'(o_vl),  64'(vl));
        chk({tag, ".en"},  64'(o_en),  64'(en));
        chk({tag, ".rs"},  64'(o_rs),  64'(rs));
        chk({tag, ".rt"},  64'(o_rt),  64'(rt));
        chk({tag, ".rd"},  64'(o_rd),  64'(rdv));
    endtask

    initial begin
        rst = 1'b1;
        i_th = '0; i_ridx = '0; i_wr_en = 1'b0; i_data = '0;
        i_adv = 1'b0; i_adv_th = '0; i_acc_we = 1'b0; i_acc_th = '0;
        i_acc_data = '0; i_rd_th = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state of every thread
        for (int t = 0; t < 8; t++) begin
            rd(3'(t));
            chk_regs($sformatf("reset_th%0d", t), '0, '0, 1'b0, '0, '0, '0);
        end
        chk("reset_active", 64'(o_active), 64'h00);

        // VL then EN on thread 3
        ecu_wr(3'd3, 3'd1, 38'd5);
        chk("active_vl_only", 64'(o_active), 64'h00);
        ecu_wr(3'd3, 3'd2, 38'd1);
        chk("active_after_en", 64'(o_active), 64'h08);
        rd(3'd3);
        chk("th3_vl", 64'(o_vl), 64'd5);
        chk("th3_en", 64'(o_en), 64'd1);

        // Truncation: EN takes bit 0 only, VL takes low 20 bits
        ecu_wr(3'd0, 3'd2, 38'h2);
        ecu_wr(3'd0, 3'd1, 38'h30_0000_0007);
        rd(3'd0);
        chk("trunc_en", 64'(o_en), 64'd0);
        chk("trunc_vl", 64'(o_vl), 64'd7);
        chk("trunc_active", 64'(o_active), 64'h08);

        // Address wrap and VL saturation on thread 3
        ecu_wr(3'd3, 3'd3, 38'h3F_FFFF_FFFF);
        ecu_wr(3'd3, 3'd1, 38'd1);
        chk("active_vl1", 64'(o_active), 64'h08);
        i_adv = 1'b1; i_adv_th = 3'd3;
        tick();
        i_adv = 1'b0;
        chk("active_clear_adv1", 64'(o_active), 64'h00);
        rd(3'd3);
        chk_regs("adv1", '0, '0, 1'b1, 38'd0, 38'd1, 38'd1);
        i_adv = 1'b1;
        tick();
        i_adv = 1'b0;
        rd(3'd3);
        chk_regs("adv2", '0, '0, 1'b1, 38'd1, 38'd2, 38'd2);
        chk("active_adv2", 64'(o_active), 64'h00);

        // Priority merge on thread 2: ECU RS, advance, acc write-back in one cycle
        ecu_wr(3'd2, 3'd1, 38'd3);
        i_th = 3'd2; i_ridx = 3'd3; i_data = 38'd100; i_wr_en = 1'b1;
        i_adv = 1'b1; i_adv_th = 3'd2;
        i_acc_we = 1'b1; i_acc_th = 3'd2; i_acc_data = 32'h3F80_0000;
        tick();
        i_wr_en = 1'b0; i_adv = 1'b0; i_acc_we = 1'b0;
        rd(3'd2);
        chk_regs("merge", 32'h3F80_0000, 20'd2, 1'b0, 38'd100, 38'd1, 38'd1);

        // ECU ACC write beats acc write-back; other thread write-back applies same cycle
        i_th = 3'd2; i_ridx = 3'd0; i_data = 38'hAAAA; i_wr_en = 1'b1;
        i_acc_we = 1'b1; i_acc_th = 3'd2; i_acc_data = 32'h5555;
        tick();
        i_acc_th = 3'd5; i_acc_data = 32'h0BAD_F00D;
        i_th = 3'd6; i_ridx = 3'd4; i_data = 38'd42;
        tick();
        i_wr_en = 1'b0; i_acc_we = 1'b0;
        rd(3'd2);
        chk("ecu_beats_wb", 64'(o_acc), 64'hAAAA);
        rd(3'd5);
        chk("wb_other_th", 64'(o_acc), 64'h0BAD_F00D);
        rd(3'd6);
        chk("ecu_other_th", 64'(o_rt), 64'd42);

        // Reserved and IGN indices drop the write
        ecu_wr(3'd3, 3'd7, '1);
        ecu_wr(3'd3, 3'd6, '1);
        rd(3'd3);
        chk_regs("ign", '0, '0, 1'b1, 38'd1, 38'd2, 38'd2);
        chk("ign_active", 64'(o_active), 64'h00);

        // Read-after-write timing on thread 1
        ecu_wr(3'd1, 3'd0, 38'h77);
        i_rd_th = 3'd1;
        ecu_wr(3'd1, 3'd0, 38'h1234);
`ifdef VXE_VPU_REGF_BYPASS_EN
        chk("raw_same_cycle", 64'(o_acc), 64'h1234);
`else
        chk("raw_same_cycle", 64'(o_acc), 64'h77);
`endif
        tick();
        chk("raw_next_cycle", 64'(o_acc), 64'h1234);

        // Reset asserted during a write discards it and clears everything
        i_th = 3'd4; i_ridx = 3'd3; i_data = 38'd55; i_wr_en = 1'b1;
        i_adv = 1'b1; i_adv_th = 3'd3;
        rst = 1'b1;
        tick();
        rst = 1'b0; i_wr_en = 1'b0; i_adv = 1'b0;
        chk_regs("rst_out", '0, '0, 1'b0, '0, '0, '0);
        for (int t = 0; t < 8; t++) begin
            rd(3'(t));
            chk_regs($sformatf("rst_mid_th%0d", t), '0, '0, 1'b0, '0, '0, '0);
        end
        chk("rst_mid_active", 64'(o_active), 64'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
